// File: rtl/lc3b_types.sv
`default_nettype none
// ---------------------------------------------------------------------------
// lc3b_types : shared LC-3b cache types and writeback buffer state encoding
// Rev 1.0
// ---------------------------------------------------------------------------
package lc3b_types;

  typedef logic [15:0]  lc3b_word;
  typedef logic [127:0] lc3b_c_block;
  typedef logic [11:0]  lc3b_c_tagline;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    DRAIN = 1'b1
  } wb_state_t;

  localparam lc3b_word WB_COUNT_MAX = 16'hFFFF;

endpackage
`default_nettype wire

// File: rtl/wb_line_reg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// wb_line_reg : line tag plus 128-bit line register, load enable, async clear
// Rev 1.0
// ---------------------------------------------------------------------------
module wb_line_reg
  import lc3b_types::*;
(
  input  logic          clk,
  input  logic          reset,
  input  logic          load,
  input  logic [11:0]   tag_in,
  input  logic [127:0]  line_in,
  output logic [11:0]   tag,
  output logic [127:0]  line
);

  lc3b_c_tagline tag_q;
  lc3b_c_block   line_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tag_q  <= '0;
      line_q <= '0;
    end else if (load) begin
      tag_q  <= tag_in;
      line_q <= line_in;
    end
  end

  assign tag  = tag_q;
  assign line = line_q;

endmodule
`default_nettype wire

// File: rtl/cache_writeback_buffer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// cache_writeback_buffer : single-entry dirty-line buffer draining to pmem
// Rev 1.0
// ---------------------------------------------------------------------------
module cache_writeback_buffer
  import lc3b_types::*;
(
  input  logic          clk,
  input  logic          reset,
  input  logic          wb_req,
  input  logic [15:0]   wb_addr,
  input  logic [127:0]  wb_data,
  output logic          wb_ack,
  output logic          full,
  output logic          pmem_write,
  output logic [15:0]   pmem_address,
  output logic [127:0]  pmem_wdata,
  input  logic          pmem_resp,
  input  logic [15:0]   lookup_addr,
  output logic          lookup_hit,
  output logic [127:0]  lookup_data,
  output logic [15:0]   wb_count
);

  wb_state_t     state;
  logic          valid;
  lc3b_word      count;
  lc3b_c_tagline tag;
  lc3b_c_block   line;
  logic          load;
  logic          unused_bits;

  // Offset bits never take part in addressing a line.
  assign unused_bits = ^{wb_addr[3:0], lookup_addr[3:0]};

  assign wb_ack = (state == IDLE) && wb_req;
  assign load   = wb_ack;

  wb_line_reg u_line (
    .clk     (clk),
    .reset   (reset),
    .load    (load),
    .tag_in  (wb_addr[15:4]),
    .line_in (wb_data),
    .tag     (tag),
    .line    (line)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      valid <= 1'b0;
      count <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (wb_req) begin
            state <= DRAIN;
            valid <= 1'b1;
          end
        end
        DRAIN: begin
          if (pmem_resp) begin
            state <= IDLE;
            valid <= 1'b0;
            if (count != WB_COUNT_MAX)
              count <= count + 16'd1;
          end
        end
        default: begin
          state <= IDLE;
          valid <= 1'b0;
        end
      endcase
    end
  end

  assign full         = (state == DRAIN);
  assign pmem_write   = (state == DRAIN);
  assign pmem_address = {tag, 4'h0};
  assign pmem_wdata   = line;

  // Hit stays up through the pmem_resp cycle; valid clears on that edge.
  assign lookup_hit  = valid && (lookup_addr[15:4] == tag);
  assign lookup_data = line;
  assign wb_count    = count;

endmodule
`default_nettype wire

// File: tb/tb_cache_writeback_buffer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_cache_writeback_buffer : scoreboard bench for cache_writeback_buffer
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_cache_writeback_buffer;

  logic          clk = 1'b0;
  logic          reset;
  logic          wb_req;
  logic [15:0]   wb_addr;
  logic [127:0]  wb_data;
  logic          wb_ack;
  logic          full;
  logic          pmem_write;
  logic [15:0]   pmem_address;
  logic [127:0]  pmem_wdata;
  logic          pmem_resp;
  logic [15:0]   lookup_addr;
  logic          lookup_hit;
  logic [127:0]  lookup_data;
  logic [15:0]   wb_count;

  int n_checks = 0;
  int n_fail   = 0;

  logic [143:0] sb_q[$];
  logic [143:0] exp_item;

  cache_writeback_buffer dut (
    .clk          (clk),
    .reset        (reset),
    .wb_req       (wb_req),
    .wb_addr      (wb_addr),
    .wb_data      (wb_data),
    .wb_ack       (wb_ack),
    .full         (full),
    .pmem_write   (pmem_write),
    .pmem_address (pmem_address),
    .pmem_wdata   (pmem_wdata),
    .pmem_resp    (pmem_resp),
    .lookup_addr  (lookup_addr),
    .lookup_hit   (lookup_hit),
    .lookup_data  (lookup_data),
    .wb_count     (wb_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Accept a line in IDLE, push the expected pmem write, drain with latency lat.
  task automatic writeback(input logic [15:0] addr, input logic [127:0] data,
                           input int lat);
    wb_req  = 1'b1;
    wb_addr = addr;
    wb_data = data;
    #1;
    n_checks++;
    if (wb_ack !== 1'b1) begin
      n_fail++;
      $display("FAIL wb_accept: wb_ack=%b expected 1", wb_ack);
    end
    if (wb_ack === 1'b1) sb_q.push_back({addr & 16'hFFF0, data});
    tick();
    wb_req = 1'b0;
    for (int i = 1; i < lat; i++) tick();
    pmem_resp = 1'b1;
    #1;
    n_checks++;
    if (pmem_write !== 1'b1) begin
      n_fail++;
      $display("FAIL wb_drain_write: pmem_write=%b expected 1", pmem_write);
    end
    if (pmem_write === 1'b1) begin
      n_checks++;
      if (sb_q.size() == 0) begin
        n_fail++;
        $display("FAIL wb_scoreboard: pmem write with empty scoreboard addr=%h", pmem_address);
      end else begin
        exp_item = sb_q.pop_front();
        if ({pmem_address, pmem_wdata} !== exp_item) begin
          n_fail++;
          $display("FAIL wb_scoreboard: addr=%h data=%h expected addr=%h data=%h",
                   pmem_address, pmem_wdata, exp_item[143:128], exp_item[127:0]);
        end
      end
    end
    tick();
    pmem_resp = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; wb_req = 1'b0; wb_addr = '0; wb_data = '0;
    pmem_resp = 1'b0; lookup_addr = '0;
    tick(); tick();
    n_checks++;
    if ({full, wb_ack, pmem_write, lookup_hit} !== 4'b0 || pmem_address !== 16'h0 ||
        pmem_wdata !== 128'h0 || lookup_data !== 128'h0 || wb_count !== 16'h0) begin
      n_fail++;
      $display("FAIL reset_values: full=%b ack=%b pw=%b hit=%b addr=%h cnt=%h expected all 0",
               full, wb_ack, pmem_write, lookup_hit, pmem_address, wb_count);
    end
    reset = 1'b0;
  endtask

  task automatic test_basic();
    wb_req = 1'b1; wb_addr = 16'h1234; wb_data = {16{8'hA5}};
    #1;
    n_checks++;
    if (wb_ack !== 1'b1) begin
      n_fail++; $display("FAIL basic_ack: wb_ack=%b expected 1", wb_ack);
    end
    sb_q.push_back({16'h1230, {16{8'hA5}}});
    tick();
    wb_req = 1'b0;
    #1;
    n_checks++;
    if (pmem_write !== 1'b1 || full !== 1'b1 || pmem_address !== 16'h1230 ||
        pmem_wdata !== {16{8'hA5}}) begin
      n_fail++;
      $display("FAIL basic_write: pw=%b full=%b addr=%h data=%h expected 1 1 1230 a5..",
               pmem_write, full, pmem_address, pmem_wdata);
    end
    tick(); tick();
    pmem_resp = 1'b1;
    #1;
    n_checks++;
    exp_item = (sb_q.size() != 0) ? sb_q.pop_front() : '1;
    if (pmem_write !== 1'b1 || {pmem_address, pmem_wdata} !== exp_item) begin
      n_fail++;
      $display("FAIL basic_scoreboard: pw=%b addr=%h expected addr=%h", pmem_write,
               pmem_address, exp_item[143:128]);
    end
    tick();
    pmem_resp = 1'b0;
    #1;
    n_checks++;
    if (full !== 1'b0 || wb_count !== 16'd1 || pmem_write !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_done: full=%b cnt=%h pw=%b expected 0 0001 0", full, wb_count, pmem_write);
    end
  endtask

  task automatic test_lookup();
    logic [127:0] d;
    d = {4{32'hDEADBEEF}};
    wb_req = 1'b1; wb_addr = 16'h1230; wb_data = d;
    #1;
    if (wb_ack === 1'b1) sb_q.push_back({16'h1230, d});
    tick();
    wb_req = 1'b0;
    lookup_addr = 16'h123E;
    #1;
    n_checks++;
    if (lookup_hit !== 1'b1 || lookup_data !== d) begin
      n_fail++;
      $display("FAIL lookup_hit: hit=%b data=%h expected 1 %h", lookup_hit, lookup_data, d);
    end
    lookup_addr = 16'h1240;
    #1;
    n_checks++;
    if (lookup_hit !== 1'b0) begin
      n_fail++; $display("FAIL lookup_miss: hit=%b expected 0", lookup_hit);
    end
    tick();
    lookup_addr = 16'h1231;
    pmem_resp = 1'b1;
    #1;
    n_checks++;
    if (lookup_hit !== 1'b1) begin
      n_fail++; $display("FAIL lookup_resp_cycle: hit=%b expected 1", lookup_hit);
    end
    exp_item = (sb_q.size() != 0) ? sb_q.pop_front() : '1;
    n_checks++;
    if ({pmem_address, pmem_wdata} !== exp_item) begin
      n_fail++;
      $display("FAIL lookup_scoreboard: addr=%h expected %h", pmem_address, exp_item[143:128]);
    end
    tick();
    pmem_resp = 1'b0;
    #1;
    n_checks++;
    if (lookup_hit !== 1'b0 || wb_count !== 16'd2) begin
      n_fail++;
      $display("FAIL lookup_after: hit=%b cnt=%h expected 0 0002", lookup_hit, wb_count);
    end
    lookup_addr = 16'h0;
  endtask

  task automatic test_back_to_back();
    wb_req = 1'b1; wb_addr = 16'h4000; wb_data = {8{16'h1111}};
    #1;
    if (wb_ack === 1'b1) sb_q.push_back({16'h4000, {8{16'h1111}}});
    tick();
    wb_addr = 16'h5678; wb_data = {8{16'h2222}};
    pmem_resp = 1'b1;
    #1;
    n_checks++;
    if (wb_ack !== 1'b0) begin
      n_fail++; $display("FAIL b2b_resp_cycle_ack: wb_ack=%b expected 0", wb_ack);
    end
    exp_item = (sb_q.size() != 0) ? sb_q.pop_front() : '1;
    n_checks++;
    if ({pmem_address, pmem_wdata} !== exp_item) begin
      n_fail++;
      $display("FAIL b2b_first_line: addr=%h expected %h", pmem_address, exp_item[143:128]);
    end
    tick();
    pmem_resp = 1'b0;
    #1;
    n_checks++;
    if (wb_ack !== 1'b1) begin
      n_fail++; $display("FAIL b2b_bubble_ack: wb_ack=%b expected 1", wb_ack);
    end
    if (wb_ack === 1'b1) sb_q.push_back({16'h5670, {8{16'h2222}}});
    tick();
    wb_req = 1'b0;
    tick();
    pmem_resp = 1'b1;
    #1;
    exp_item = (sb_q.size() != 0) ? sb_q.pop_front() : '1;
    n_checks++;
    if (pmem_write !== 1'b1 || {pmem_address, pmem_wdata} !== exp_item) begin
      n_fail++;
      $display("FAIL b2b_second_line: pw=%b addr=%h expected %h", pmem_write, pmem_address,
               exp_item[143:128]);
    end
    tick();
    pmem_resp = 1'b0;
    #1;
    n_checks++;
    if (wb_count !== 16'd4) begin
      n_fail++; $display("FAIL b2b_count: cnt=%h expected 0004", wb_count);
    end
  endtask

  task automatic test_idle_resp();
    pmem_resp = 1'b1;
    tick();
    tick();
    pmem_resp = 1'b0;
    #1;
    n_checks++;
    if (full !== 1'b0 || pmem_write !== 1'b0 || wb_count !== 16'd4) begin
      n_fail++;
      $display("FAIL idle_resp: full=%b pw=%b cnt=%h expected 0 0 0004", full, pmem_write, wb_count);
    end
  endtask

  task automatic test_reset_mid_drain();
    wb_req = 1'b1; wb_addr = 16'hBEEF; wb_data = {32{4'h7}};
    tick();
    wb_req = 1'b0;
    lookup_addr = 16'hBEE0;
    #1;
    n_checks++;
    if (pmem_write !== 1'b1 || lookup_hit !== 1'b1) begin
      n_fail++; $display("FAIL mid_drain_pre: pw=%b hit=%b expected 1 1", pmem_write, lookup_hit);
    end
    reset = 1'b1;
    #1;
    n_checks++;
    if (pmem_write !== 1'b0 || full !== 1'b0 || wb_count !== 16'h0 || lookup_hit !== 1'b0 ||
        pmem_address !== 16'h0) begin
      n_fail++;
      $display("FAIL mid_drain_reset: pw=%b full=%b cnt=%h hit=%b addr=%h expected 0 0 0 0 0",
               pmem_write, full, wb_count, lookup_hit, pmem_address);
    end
    sb_q.delete();
    tick();
    reset = 1'b0;
    lookup_addr = 16'h0;
  endtask

  task automatic test_saturation();
    force dut.count = 16'hFFFE;
    #1;
    release dut.count;
    for (int k = 0; k < 3; k++) begin
      writeback(16'h0100 + 16'(k) * 16'h10, {4{32'h0 + k}}, 2);
      n_checks++;
      if (wb_count !== 16'hFFFF) begin
        n_fail++; $display("FAIL saturation_%0d: cnt=%h expected ffff", k, wb_count);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_lookup();
    test_back_to_back();
    test_idle_resp();
    test_reset_mid_drain();
    writeback(16'h2AB7, {2{64'h0123456789ABCDEF}}, 1);
    n_checks++;
    if (wb_count !== 16'd1) begin
      n_fail++; $display("FAIL post_reset_count: cnt=%h expected 0001", wb_count);
    end
    test_saturation();
    n_checks++;
    if (sb_q.size() != 0) begin
      n_fail++; $display("FAIL scoreboard_empty: %0d left expected 0", sb_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/cache_writeback_buffer.md
# cache_writeback_buffer

Single-entry writeback buffer between the L1 cache datapath and physical memory. When the cache controller evicts a dirty line, it hands the line to this block and proceeds immediately with its refill. The buffer then drains the line to physical memory over the pmem write handshake. A combinational address-match port lets the cache forward buffered data on a miss to the line currently being drained.

## Interface
- No parameters; widths come from `lc3b_types`.
- `clk` in 1: sole clock, rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `wb_req` in 1: cache requests writeback of an evicted dirty line.
- `wb_addr` in 16 (`lc3b_word`): line address of the evicted line; bits [3:0] ignored.
- `wb_data` in 128 (`lc3b_c_block`): evicted line contents.
- `wb_ack` out 1: line accepted this cycle (combinational).
- `full` out 1: buffer occupied; new requests are not accepted.
- `pmem_write` out 1: write request to physical memory.
- `pmem_address` out 16: line-aligned address, bits [3:0] = 0.
- `pmem_wdata` out 128: line being written.
- `pmem_resp` in 1: memory completed the write.
- `lookup_addr` in 16: miss address probed by the cache.
- `lookup_hit` out 1: `lookup_addr[15:4]` matches the buffered line while it is valid.
- `lookup_data` out 128: buffered line; valid when `lookup_hit` = 1.
- `wb_count` out 16: saturating count of completed writebacks.

## Operation
- State machine states:
  - `IDLE`: empty.
  - `DRAIN`: holding a line and driving the pmem write.
- Transitions:
  - In `IDLE`: `wb_ack` = `wb_req`. On the accepting edge, capture `wb_addr` with bits [3:0] zeroed, capture `wb_data`, set `valid`, and go to `DRAIN`.
  - In `DRAIN`: `pmem_write` = 1, and address and data are held stable. On an edge with `pmem_resp` = 1, clear `valid`, increment `wb_count`, and return to `IDLE`.
- `full` = (state == `DRAIN`).
- `wb_ack` = 0 in `DRAIN`. The cache must hold `wb_req`, `wb_addr` and `wb_data` until it sees `wb_ack`.
- `lookup_hit` = `valid` & (`lookup_addr[15:4]` == stored `addr[15:4]`). `lookup_data` = stored line; it stays driven when there is no hit.
- `wb_count` saturates at 16'hFFFF and never wraps.
- Boundary conditions:
  - `pmem_resp` in `IDLE`: ignored, no state change, count unchanged.
  - `pmem_resp` and `wb_req` in the same `DRAIN` cycle: the request is not accepted that cycle. The next cycle is `IDLE`, where it is accepted. Back-to-back writebacks therefore cost at least one bubble cycle.
  - `lookup_addr` matching on the `pmem_resp` cycle: `lookup_hit` = 1 that cycle and 0 from the next cycle on.
  - `wb_req` in the first cycle after reset deasserts: accepted normally.
- Reset, including mid-`DRAIN`:
  - State goes to `IDLE` and `valid` = 0 immediately (asynchronous).
  - `pmem_write` = 0, `wb_count` = 0.
  - Address and data registers are cleared to 0.
  - An in-flight line is discarded; the memory side must tolerate the request being abandoned.

## Timing
- Reset values:
  - `full` = 0, `wb_ack` = 0, `pmem_write` = 0, `lookup_hit` = 0.
  - `pmem_address` = 0, `pmem_wdata` = 0, `lookup_data` = 0, `wb_count` = 0.
- Acceptance: zero-latency combinational `wb_ack`. `pmem_write` rises in the cycle after acceptance.
- Drain latency: N + 1 cycles from acceptance to `IDLE`, where N is the memory's response latency in cycles.
- `pmem_write`, `pmem_address` and `pmem_wdata` come straight from registers and state, so there is no combinational path from any input to them.
- `lookup_hit` and `lookup_data` depend combinationally on `lookup_addr` only, not on `wb_*`.

## Structure
- Add to `lc3b_types`:
  - `lc3b_c_block` (128 bits) and `lc3b_c_tagline` (12 bits, address [15:4]), if absent.
  - A `wb_state_t` enum with `IDLE` and `DRAIN`.
- One natural sub-module, `wb_line_reg`: a 12-bit tag plus a 128-bit line register with load enable and async clear.
- The FSM, counter and compare logic live in the top module.

## Test plan
- Reset, then `wb_req` = 1 with addr 16'h1234, data 128'hA5…A5:
  - `wb_ack` = 1 that cycle.
  - Next cycle: `pmem_write` = 1, `pmem_address` = 16'h1230, `pmem_wdata` = A5…A5.
  - `pmem_resp` after 3 cycles gives `full` = 0 next cycle and `wb_count` = 1.
- While draining line 16'h1230:
  - `lookup_addr` = 16'h123E gives `lookup_hit` = 1 and the buffered data.
  - `lookup_addr` = 16'h1240 gives `lookup_hit` = 0.
- Hold `wb_req` during `DRAIN` with `pmem_resp` asserted in the same cycle: `wb_ack` = 0 that cycle and 1 the following cycle, with the second line captured.
- Assert `reset` mid-`DRAIN`: `pmem_write` and `full` drop before the next edge, `wb_count` = 0, `lookup_hit` = 0.
- `pmem_resp` pulsed while `IDLE`: no state change, `wb_count` unchanged.
- Preload `wb_count` near saturation by forcing it to 16'hFFFE, then run 3 writebacks: the count reads FFFF and stays there.
